imem_arbiter: RTL

- Shares the single-port synchronous instruction memory between two requesters:
  - the fetch stage (read-only, one word per cycle);
  - the program loader (boot/debug read and write).
- Sits between the fetch stage's PC/instruction-memory path and the memory macro.
- Generates the fetch-stage stall whenever fetch loses arbitration.
- Kills the in-flight fetch response on a pipeline flush.

---
 rtl/imem_arbiter_if.sv | 66 ++++++
 rtl/imem_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_arbiter_if
// Description : Bus bundle between the fetch stage, the program loader, the
//               instruction-memory arbiter and the single-port memory macro.
//               The arbiter connects through the 'slave' modport; the
//               environment (fetch stage, loader and memory) uses 'master'.
//               Signal groups:
//                 f_*   fetch read port (req/addr/flush in, gnt/stall/rvalid/
//                       rdata out)
//                 l_*   loader read/write port (req/we/lock/addr/wdata in,
//                       gnt/rvalid/rdata out)
//                 mem_* memory macro port (en/we/addr/wdata out, rdata in)
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Fetch requester
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_flush;
    logic              f_gnt;
    logic              f_stall;
    logic              f_rvalid;
    logic [DATA_W-1:0] f_rdata;

    // Program loader
    logic              l_req;
    logic              l_we;
    logic              l_lock;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic              l_gnt;
    logic              l_rvalid;
    logic [DATA_W-1:0] l_rdata;

    // Memory macro
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter view
    modport slave (
        input  f_req, f_addr, f_flush,
        output f_gnt, f_stall, f_rvalid, f_rdata,
        input  l_req, l_we, l_lock, l_addr, l_wdata,
        output l_gnt, l_rvalid, l_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Environment view (requesters and memory)
    modport master (
        output f_req, f_addr, f_flush,
        input  f_gnt, f_stall, f_rvalid, f_rdata,
        output l_req, l_we, l_lock, l_addr, l_wdata,
        input  l_gnt, l_rvalid, l_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imem_arbiter
// Description : Arbitrates the single-port synchronous instruction memory
//               between the fetch stage (read-only) and the program loader
//               (read/write). Fetch has priority but is limited to
//               FETCH_BURST_MAX consecutive grants while the loader waits.
//               The loader can lock the memory for exclusive use. A pipeline
//               flush kills the outstanding fetch response.
// Ports       : clk  - core clock
//               rst  - asynchronous active-high reset
//               bus  - imem_arbiter_if.slave (fetch, loader and memory ports)
//               perf_stall_cnt / perf_kill_cnt - only with the optional
//               feature macro IMEM_ARBITER_PERF_EN defined: saturating count
//               of fetch stall cycles and of suppressed fetch responses.
// Parameters  : ADDR_W, DATA_W, FETCH_BURST_MAX (1..255)
// Revision    : 1.0 - initial release
// ============================================================================
module imem_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int FETCH_BURST_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    imem_arbiter_if.slave     bus
`ifdef IMEM_ARBITER_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [15:0]       perf_kill_cnt
`endif
);

    // ------------------------------------------------------------------------
    // Constants and types
    // ------------------------------------------------------------------------
    localparam logic [7:0]        c_burst_max = 8'(FETCH_BURST_MAX);
    // Word alignment: the two byte-offset bits never reach the memory.
    localparam logic [ADDR_W-1:0] c_addr_mask = ~(ADDR_W'(3));

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_FETCH  = 2'd1,
        OWN_LOADER = 2'd2
    } owner_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t     r_state;
    logic [7:0] r_burst_cnt;
    owner_t     r_rd_owner;
    logic       r_f_kill;

    // ------------------------------------------------------------------------
    // Grant decision
    // ------------------------------------------------------------------------
    logic w_burst_hit;
    logic w_f_gnt;
    logic w_l_gnt;
    logic w_f_stall;
    logic w_f_rvalid;
    logic w_l_rvalid;

    // Fetch has used up its quota while the loader is waiting.
    assign w_burst_hit = bus.l_req && (r_burst_cnt == c_burst_max);

    always_comb begin
        w_f_gnt = 1'b0;
        w_l_gnt = 1'b0;
        // Grants are suppressed while reset is asserted so that every
        // output reads 0 during reset, not only after the first edge.
        if (!rst) begin
            case (r_state)
                ST_RUN: begin
                    if (bus.f_req && !w_burst_hit) begin
                        w_f_gnt = 1'b1;
                    end else if (bus.l_req) begin
                        w_l_gnt = 1'b1;
                    end
                end
                ST_LOCK: begin
                    w_l_gnt = bus.l_req;
                end
                default: begin
                    w_f_gnt = 1'b0;
                    w_l_gnt = 1'b0;
                end
            endcase
        end
    end

    assign w_f_stall = bus.f_req && !w_f_gnt && !rst;

    // A fetch response is dropped if the read was killed at grant time or
    // if a flush arrives in the response cycle itself.
    assign w_f_rvalid = (r_rd_owner == OWN_FETCH) && !r_f_kill && !bus.f_flush;
    assign w_l_rvalid = (r_rd_owner == OWN_LOADER);

    // ------------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------------
    assign bus.f_gnt    = w_f_gnt;
    assign bus.l_gnt    = w_l_gnt;
    assign bus.f_stall  = w_f_stall;

    assign bus.f_rvalid = w_f_rvalid;
    assign bus.f_rdata  = w_f_rvalid ? bus.mem_rdata : '0;
    assign bus.l_rvalid = w_l_rvalid;
    assign bus.l_rdata  = w_l_rvalid ? bus.mem_rdata : '0;

    assign bus.mem_en    = w_f_gnt || w_l_gnt;
    assign bus.mem_we    = w_l_gnt && bus.l_we;
    assign bus.mem_addr  = w_f_gnt ? (bus.f_addr & c_addr_mask) :
                           w_l_gnt ? (bus.l_addr & c_addr_mask) : '0;
    assign bus.mem_wdata = (w_l_gnt && bus.l_we) ? bus.l_wdata : '0;

    // ------------------------------------------------------------------------
    // FSM, burst counter, read-owner tracking
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_burst_cnt <= 8'd0;
            r_rd_owner  <= OWN_NONE;
            r_f_kill    <= 1'b0;
        end else begin
            // Lock takes effect one cycle after l_lock rises and releases
            // one cycle after it falls; a grant in the transition cycle is
            // decided by the current state and completes normally.
            case (r_state)
                ST_RUN:  r_state <= bus.l_lock ? ST_LOCK : ST_RUN;
                ST_LOCK: r_state <= bus.l_lock ? ST_LOCK : ST_RUN;
                default: r_state <= ST_RUN;
            endcase

            // Counts fetch grants that overtook a waiting loader.
            if (w_l_gnt || !bus.l_req) begin
                r_burst_cnt <= 8'd0;
            end else if (w_f_gnt && (r_burst_cnt != c_burst_max)) begin
                r_burst_cnt <= r_burst_cnt + 8'd1;
            end

            if (w_f_gnt) begin
                r_rd_owner <= OWN_FETCH;
            end else if (w_l_gnt && !bus.l_we) begin
                r_rd_owner <= OWN_LOADER;
            end else begin
                r_rd_owner <= OWN_NONE;
            end

            r_f_kill <= w_f_gnt && bus.f_flush;
        end
    end

`ifdef IMEM_ARBITER_PERF_EN
    // ------------------------------------------------------------------------
    // Performance counters (saturating)
    // ------------------------------------------------------------------------
    logic        w_kill_evt;
    logic [31:0] r_perf_stall;
    logic [15:0] r_perf_kill;

    assign w_kill_evt = (r_rd_owner == OWN_FETCH) && (r_f_kill || bus.f_flush);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_stall <= 32'd0;
            r_perf_kill  <= 16'd0;
        end else begin
            if (w_f_stall && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (w_kill_evt && (r_perf_kill != 16'hFFFF)) begin
                r_perf_kill <= r_perf_kill + 16'd1;
            end
        end
    end

    assign perf_stall_cnt = r_perf_stall;
    assign perf_kill_cnt  = r_perf_kill;
`endif

endmodule
`default_nettype wire
